// File: rtl/base_arr_arb_skid.sv
// base_arr_arb_skid: muxes the arbiter grant into a 2-entry skid FIFO tagging id/beat and flagging protocol errors
module base_arr_arb_skid #(
    parameter int ways  = 1,
    parameter int width = 8,
    parameter int bcw   = 4,
    parameter int idw   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   arb_r,
    input  logic                   arb_v,
    input  logic [0:ways-1]        arb_s,
    input  logic                   arb_h,
    input  logic [0:ways*width-1]  din,
    input  logic                   o_r,
    output logic                   o_v,
    output logic [0:width-1]       o_d,
    output logic [0:idw-1]         o_id,
    output logic                   o_h,
    output logic [0:bcw-1]         o_beat,
    output logic                   o_err
);
    logic [width-1:0] d_q [2];
    logic [idw-1:0]   id_q [2];
    logic [bcw-1:0]   beat_q [2];
    logic [1:0]       h_q;
    logic [1:0]       cnt_q;
    logic             rd_q, wr_q, lock_q, err_q;
    logic [idw-1:0]   lock_id_q;
    logic [bcw-1:0]   ctr_q, ctr_d;
    logic [width-1:0] sel_d;
    logic [idw-1:0]   id_d;
    logic             bad_d, push, pop;

    assign arb_r  = cnt_q != 2'd2;
    assign o_v    = cnt_q != 2'd0;
    assign push   = arb_v & arb_r;
    assign pop    = o_v & o_r;
    assign o_d    = d_q[rd_q];
    assign o_id   = id_q[rd_q];
    assign o_h    = h_q[rd_q];
    assign o_beat = beat_q[rd_q];
    assign o_err  = err_q;

    // descending scan so the lowest set select bit wins the id
    always_comb begin
        sel_d = '0;
        id_d  = '0;
        for (int i = ways - 1; i >= 0; i--) begin
            sel_d = sel_d | (arb_s[i] ? din[i*width +: width] : '0);
            id_d  = arb_s[i] ? idw'(i) : id_d;
        end
        bad_d = (arb_s == '0) || ($countones(arb_s) > 1) || (lock_q && id_d != lock_id_q);
        ctr_d = !arb_h ? '0 : (&ctr_q ? ctr_q : ctr_q + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            ctr_q     <= '0;
            err_q     <= 1'b0;
            h_q       <= '0;
            for (int k = 0; k < 2; k++) begin
                d_q[k]    <= '0;
                id_q[k]   <= '0;
                beat_q[k] <= '0;
            end
        end else begin
            if (push) begin
                d_q[wr_q]    <= sel_d;
                id_q[wr_q]   <= id_d;
                h_q[wr_q]    <= arb_h;
                beat_q[wr_q] <= ctr_q;
                wr_q         <= ~wr_q;
                ctr_q        <= ctr_d;
                lock_q       <= arb_h;
                lock_id_q    <= id_d;
                err_q        <= err_q | bad_d;
            end
            if (pop)
                rd_q <= ~rd_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_base_arr_arb_skid.sv
// tb_base_arr_arb_skid: directed steps with a queue scoreboard of expected beats
module tb_base_arr_arb_skid;
    localparam int WAYS = 4, W = 8, BCW = 2, IDW = 2;

    logic              clk = 1'b0, reset = 1'b1;
    logic              arb_r, arb_v = 1'b0, arb_h = 1'b0, o_r = 1'b0;
    logic [0:WAYS-1]   arb_s = '0;
    logic [0:WAYS*W-1] din = '0;
    logic              o_v, o_h, o_err;
    logic [0:W-1]      o_d;
    logic [0:IDW-1]    o_id;
    logic [0:BCW-1]    o_beat;

    base_arr_arb_skid #(.ways(WAYS), .width(W), .bcw(BCW), .idw(IDW)) dut (
        .clk(clk), .reset(reset), .arb_r(arb_r), .arb_v(arb_v), .arb_s(arb_s),
        .arb_h(arb_h), .din(din), .o_r(o_r), .o_v(o_v), .o_d(o_d), .o_id(o_id),
        .o_h(o_h), .o_beat(o_beat), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]   d;
        logic [IDW-1:0] id;
        logic           h;
        logic [BCW-1:0] beat;
    } beat_t;

    beat_t          sb[$];
    int             tests = 0, fails = 0;
    logic [BCW-1:0] m_ctr = '0;
    logic           m_lock = 1'b0, m_err = 1'b0;
    logic [IDW-1:0] m_lock_id = '0;
    logic [7:0]     ways_d [WAYS];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_din(input logic [7:0] a, b, c, d);
        ways_d[0] = a; ways_d[1] = b; ways_d[2] = c; ways_d[3] = d;
        for (int i = 0; i < WAYS; i++) din[i*W +: W] = ways_d[i];
    endtask

    // s[i] selects way i, so 4'b0010 is way 1
    task automatic step(input logic v, input logic [3:0] s, input logic h, input logic r);
        beat_t e, got;
        int    ones;
        logic  pu, po;
        arb_v = v; arb_h = h; o_r = r;
        for (int i = 0; i < WAYS; i++) arb_s[i] = s[i];
        #1;
        chk("arb_r", 32'(arb_r), 32'(sb.size() != 2));
        chk("o_v", 32'(o_v), 32'(sb.size() != 0));
        chk("o_err", 32'(o_err), 32'(m_err));
        pu = v && sb.size() != 2;
        po = r && sb.size() != 0;
        if (po) begin
            e = sb.pop_front();
            got = '{d: o_d, id: o_id, h: o_h, beat: o_beat};
            chk("o_d", 32'(got.d), 32'(e.d));
            chk("o_id", 32'(got.id), 32'(e.id));
            chk("o_h", 32'(got.h), 32'(e.h));
            chk("o_beat", 32'(got.beat), 32'(e.beat));
        end
        if (pu) begin
            e = '0;
            ones = 0;
            for (int i = WAYS - 1; i >= 0; i--) if (s[i]) begin
                e.d |= ways_d[i];
                e.id = IDW'(i);
                ones++;
            end
            e.h = h;
            e.beat = m_ctr;
            if (ones != 1 || (m_lock && e.id != m_lock_id)) m_err = 1'b1;
            m_lock = h;
            m_lock_id = e.id;
            m_ctr = !h ? '0 : (m_ctr == '1 ? m_ctr : m_ctr + 1'b1);
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; arb_v = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        m_ctr = '0; m_lock = 1'b0; m_lock_id = '0; m_err = 1'b0;
        chk("rst_o_v", 32'(o_v), 32'd0);
        chk("rst_arb_r", 32'(arb_r), 32'd1);
        chk("rst_o_err", 32'(o_err), 32'd0);
        chk("rst_o_d", 32'(o_d), 32'd0);
        chk("rst_o_id", 32'(o_id), 32'd0);
        chk("rst_o_h", 32'(o_h), 32'd0);
        chk("rst_o_beat", 32'(o_beat), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, 1'b0, 1'b1);
        chk("drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        // single beat on way 1
        set_din(8'h11, 8'hA5, 8'h33, 8'h44);
        step(1'b1, 4'b0010, 1'b0, 1'b1);
        step(1'b0, 4'b0000, 1'b0, 1'b1);
        drain();
        // back-pressure: third beat held until space returns
        set_din(8'd1, 8'h0, 8'h0, 8'h0);
        step(1'b1, 4'b0001, 1'b0, 1'b0);
        set_din(8'd2, 8'h0, 8'h0, 8'h0);
        step(1'b1, 4'b0001, 1'b0, 1'b0);
        set_din(8'd3, 8'h0, 8'h0, 8'h0);
        step(1'b1, 4'b0001, 1'b0, 1'b0);
        step(1'b1, 4'b0001, 1'b0, 1'b1);
        step(1'b1, 4'b0001, 1'b0, 1'b1);
        drain();
        // 4-beat burst on way 2
        for (int i = 0; i < 4; i++) begin
            set_din(8'h0, 8'h0, 8'(10 + i), 8'h0);
            step(1'b1, 4'b0100, i != 3, 1'b1);
        end
        drain();
        // 6-beat burst saturates the 2-bit beat counter, then a fresh burst
        for (int i = 0; i < 6; i++) begin
            set_din(8'h0, 8'h0, 8'h0, 8'(20 + i));
            step(1'b1, 4'b1000, i != 5, 1'b1);
        end
        set_din(8'h77, 8'h0, 8'h0, 8'h0);
        step(1'b1, 4'b0001, 1'b1, 1'b1);
        step(1'b1, 4'b0001, 1'b0, 1'b1);
        drain();
        // locked on way 3, grant to way 0 is an error and sticks
        set_din(8'h5A, 8'h0, 8'h0, 8'hC3);
        step(1'b1, 4'b1000, 1'b1, 1'b1);
        step(1'b1, 4'b0001, 1'b0, 1'b1);
        step(1'b1, 4'b0001, 1'b0, 1'b1);
        drain();
        do_reset();
        set_din(8'h01, 8'h02, 8'h04, 8'h08);
        step(1'b1, 4'b0110, 1'b0, 1'b1);
        drain();
        do_reset();
        step(1'b1, 4'b0000, 1'b0, 1'b1);
        drain();
        // reset while full drops entries and restarts beat count
        do_reset();
        set_din(8'h0, 8'h0, 8'h0, 8'h99);
        step(1'b1, 4'b1000, 1'b1, 1'b0);
        step(1'b1, 4'b1000, 1'b1, 1'b0);
        step(1'b0, 4'b0000, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 4'b1000, 1'b0, 1'b1);
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
